// File: rtl/maq_est_y_modos_ctrl_if.sv
// Button/display bundle for the virtual-pet controller.
// The user side drives the buttons; the pet controller drives the levels, state and mode.
interface maq_est_y_modos_ctrl_if;
    logic       Boton_Comida;
    logic       Boton_Medicina;
    logic [2:0] nivel_comida;
    logic [2:0] nivel_salud;
    logic [2:0] estado;
    logic [1:0] modo;

    modport master (
        output Boton_Comida,
        output Boton_Medicina,
        input  nivel_comida,
        input  nivel_salud,
        input  estado,
        input  modo
    );

    modport slave (
        input  Boton_Comida,
        input  Boton_Medicina,
        output nivel_comida,
        output nivel_salud,
        output estado,
        output modo
    );
endinterface

// File: rtl/maq_est_y_modos_ctrl.sv
// Virtual-pet controller: two decaying 3-bit well-being levels, button-driven
// replenishment, a registered pet state derived from the levels and a short
// care-mode indication after each accepted press. MUERTO freezes everything
// until the asynchronous active-low reset.
module maq_est_y_modos_ctrl #(
    parameter int CICLOS_HAMBRE = 50,
    parameter int CICLOS_SALUD  = 100,
    parameter int CICLOS_MODO   = 8,
    parameter int INCREMENTO    = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    maq_est_y_modos_ctrl_if.slave       bus
);

    localparam int HW = $clog2(CICLOS_HAMBRE);
    localparam int SW = $clog2(CICLOS_SALUD);
    localparam int TW = $clog2(CICLOS_MODO + 1);

    typedef enum logic [2:0] {
        FELIZ      = 3'd0,
        NEUTRO     = 3'd1,
        HAMBRIENTO = 3'd2,
        ENFERMO    = 3'd3,
        MUERTO     = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        COMIENDO = 2'd1,
        CURANDO  = 2'd2
    } modo_t;

    // Bit 0 = feed button, bit 1 = medicine button.
    logic [1:0] btn_raw;
    logic [1:0] pulse;

    assign btn_raw = {bus.Boton_Medicina, bus.Boton_Comida};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;

            // Two-flop synchronizer followed by a delayed copy for edge detection.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= sync2_reg;
                end
            end

            // One pulse per press regardless of how long the button is held.
            assign pulse[gi] = sync2_reg & ~prev_reg;
        end
    endgenerate

    logic [HW-1:0] cnt_h_reg, cnt_h_next;
    logic [SW-1:0] cnt_s_reg, cnt_s_next;
    logic [2:0]    comida_reg, comida_next;
    logic [2:0]    salud_reg, salud_next;
    logic [TW-1:0] timer_reg, timer_next;
    estado_t       state_reg, state_next;
    modo_t         modo_reg, modo_next;

    logic tick_h;
    logic tick_s;

    assign tick_h = (cnt_h_reg == HW'(CICLOS_HAMBRE - 1));
    assign tick_s = (cnt_s_reg == SW'(CICLOS_SALUD - 1));

    // Add the press gain, remove the decay step, then clamp into 0..7.
    function automatic logic [2:0] sat_level(input logic [2:0] lvl,
                                             input logic inc,
                                             input logic dec);
        int v;
        v = int'(lvl);
        if (inc) v = v + INCREMENTO;
        if (dec) v = v - 1;
        if (v < 0)
            v = 0;
        else if (v > 7)
            v = 7;
        return v[2:0];
    endfunction

    // Next-state logic: decay, replenishment, care-mode timer and pet state.
    always_comb begin
        cnt_h_next  = cnt_h_reg;
        cnt_s_next  = cnt_s_reg;
        comida_next = comida_reg;
        salud_next  = salud_reg;
        timer_next  = timer_reg;
        modo_next   = modo_reg;
        state_next  = state_reg;

        if (state_reg == MUERTO) begin
            // Dead pet: levels and counters frozen, presses ignored.
            state_next = MUERTO;
            modo_next  = NORMAL;
            timer_next = '0;
        end else begin
            cnt_h_next  = tick_h ? '0 : cnt_h_reg + 1'b1;
            cnt_s_next  = tick_s ? '0 : cnt_s_reg + 1'b1;
            comida_next = sat_level(comida_reg, pulse[0], tick_h);
            salud_next  = sat_level(salud_reg, pulse[1], tick_s);

            // Feed wins the mode when both buttons land in the same cycle.
            if (pulse[0]) begin
                modo_next  = COMIENDO;
                timer_next = TW'(CICLOS_MODO);
            end else if (pulse[1]) begin
                modo_next  = CURANDO;
                timer_next = TW'(CICLOS_MODO);
            end else if (timer_reg != '0) begin
                timer_next = timer_reg - 1'b1;
                if (timer_reg == TW'(1))
                    modo_next = NORMAL;
            end

            // State lags the levels by one cycle.
            if (comida_reg == 3'd0 && salud_reg == 3'd0)
                state_next = MUERTO;
            else if (salud_reg <= 3'd2)
                state_next = ENFERMO;
            else if (comida_reg <= 3'd2)
                state_next = HAMBRIENTO;
            else if (comida_reg >= 3'd5 && salud_reg >= 3'd5)
                state_next = FELIZ;
            else
                state_next = NEUTRO;
        end
    end

    // State register; reset returns a full, happy pet at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_h_reg  <= '0;
            cnt_s_reg  <= '0;
            comida_reg <= 3'd7;
            salud_reg  <= 3'd7;
            timer_reg  <= '0;
            modo_reg   <= NORMAL;
            state_reg  <= FELIZ;
        end else begin
            cnt_h_reg  <= cnt_h_next;
            cnt_s_reg  <= cnt_s_next;
            comida_reg <= comida_next;
            salud_reg  <= salud_next;
            timer_reg  <= timer_next;
            modo_reg   <= modo_next;
            state_reg  <= state_next;
        end
    end

    assign bus.nivel_comida = comida_reg;
    assign bus.nivel_salud  = salud_reg;
    assign bus.estado       = state_reg;
    assign bus.modo         = modo_reg;

endmodule

// File: tb/tb_maq_est_y_modos_ctrl.sv
// Self-checking bench for the virtual-pet controller: directed scenarios plus
// random press sequences, compared every cycle against a time-based model.
module tb_maq_est_y_modos_ctrl;

    localparam int T_HAMBRE = 50;
    localparam int T_SALUD  = 100;
    localparam int T_MODO   = 8;
    localparam int INC      = 2;

    logic clk;
    logic reset;
    logic bc;
    logic bm;

    int vectors;
    int miscompares;

    // Reference model: levels, state, mode, cycles since reset release.
    int m_com, m_sal, m_est, m_mode, mode_end, t;
    int hc[3];
    int hm[3];

    maq_est_y_modos_ctrl_if bus ();

    assign bus.Boton_Comida   = bc;
    assign bus.Boton_Medicina = bm;

    maq_est_y_modos_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp7(input int v);
        if (v < 0) return 0;
        if (v > 7) return 7;
        return v;
    endfunction

    function automatic int classify(input int c, input int s);
        if (c == 0 && s == 0) return 4;
        if (s <= 2) return 3;
        if (c <= 2) return 2;
        if (c >= 5 && s >= 5) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_com = 7; m_sal = 7; m_est = 0; m_mode = 0; mode_end = 0; t = 0;
        for (int i = 0; i < 3; i++) begin
            hc[i] = 0;
            hm[i] = 0;
        end
    endtask

    // One rising edge of the pet: a press counts when the sample two edges
    // ago is high and the one before it low; decay on multiples of the period.
    task automatic model_edge();
        int pc, pm, dc, ds, new_est;
        t++;
        pc = (hc[1] != 0 && hc[2] == 0) ? 1 : 0;
        pm = (hm[1] != 0 && hm[2] == 0) ? 1 : 0;
        hc[2] = hc[1]; hc[1] = hc[0]; hc[0] = int'(bc);
        hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = int'(bm);
        if (m_est == 4) begin
            m_mode = 0;
        end else begin
            dc = (t % T_HAMBRE == 0) ? 1 : 0;
            ds = (t % T_SALUD == 0) ? 1 : 0;
            new_est = classify(m_com, m_sal);
            m_com = clamp7(m_com + INC * pc - dc);
            m_sal = clamp7(m_sal + INC * pm - ds);
            if (pc != 0) begin
                m_mode = 1; mode_end = t + T_MODO;
            end else if (pm != 0) begin
                m_mode = 2; mode_end = t + T_MODO;
            end else if (t >= mode_end) begin
                m_mode = 0;
            end
            m_est = new_est;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_comida"}, 8'(bus.nivel_comida), 8'(m_com));
        chk({tag, "_salud"},  8'(bus.nivel_salud),  8'(m_sal));
        chk({tag, "_estado"}, 8'(bus.estado),       8'(m_est));
        chk({tag, "_modo"},   8'(bus.modo),         8'(m_mode));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_comida"}, 8'(bus.nivel_comida), 8'd7);
        chk({tag, "_salud"},  8'(bus.nivel_salud),  8'd7);
        chk({tag, "_estado"}, 8'(bus.estado),       8'd0);
        chk({tag, "_modo"},   8'(bus.modo),         8'd0);
    endtask

    // Advance one clock and compare all outputs just after the edge.
    task automatic step();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        chk_model("cyc");
    endtask

    task automatic assert_reset_now(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        chk_reset_vals(tag);
    endtask

    initial begin
        int combo, hold, gap;
        vectors = 0;
        miscompares = 0;
        bc = 1'b0;
        bm = 1'b0;
        reset = 1'b1;
        #2;
        assert_reset_now("rst_init");

        // Reset held with buttons toggling: outputs stay at reset values.
        for (int i = 0; i < 10; i++) begin
            bc = 1'($urandom);
            bm = 1'($urandom);
            step();
            chk_reset_vals("rst_hold");
        end
        bc = 1'b0;
        bm = 1'b0;
        step();
        reset = 1'b1;

        // Idle decay from full levels.
        repeat (49) step();
        chk("hold49_comida", 8'(bus.nivel_comida), 8'd7);
        while (t < 250) step();
        chk("t250_comida", 8'(bus.nivel_comida), 8'd2);
        chk("t250_salud", 8'(bus.nivel_salud), 8'd5);
        step();
        chk("t251_estado", 8'(bus.estado), 8'd2);

        // Long feed press: exactly one increment, mode for 8 cycles.
        bc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 2)  chk("feed_pre_comida", 8'(bus.nivel_comida), 8'd2);
            if (i == 3)  chk("feed_inc_comida", 8'(bus.nivel_comida), 8'd4);
            if (i == 3)  chk("feed_modo_on", 8'(bus.modo), 8'd1);
            if (i == 10) chk("feed_modo_last", 8'(bus.modo), 8'd1);
            if (i == 11) chk("feed_modo_off", 8'(bus.modo), 8'd0);
        end
        bc = 1'b0;
        repeat (5) step();
        chk("feed_neutro", 8'(bus.estado), 8'd1);

        // Random press patterns checked against the model every cycle.
        for (int n = 0; n < 30; n++) begin
            combo = int'($urandom_range(1, 3));
            hold  = int'($urandom_range(1, 5));
            gap   = int'($urandom_range(2, 14));
            bc = combo[0];
            bm = combo[1];
            repeat (hold) step();
            bc = 1'b0;
            bm = 1'b0;
            repeat (gap) step();
        end

        // Feed at level 7 and both buttons together.
        assert_reset_now("rst_b");
        repeat (3) step();
        reset = 1'b1;
        bc = 1'b1;
        step();
        step();
        bc = 1'b0;
        step();
        chk("feed7_comida", 8'(bus.nivel_comida), 8'd7);
        chk("feed7_modo", 8'(bus.modo), 8'd1);
        while (t < 157) step();
        bc = 1'b1;
        bm = 1'b1;
        step();
        bc = 1'b0;
        bm = 1'b0;
        step();
        step();
        chk("both_comida", 8'(bus.nivel_comida), 8'd6);
        chk("both_salud", 8'(bus.nivel_salud), 8'd7);
        chk("both_modo", 8'(bus.modo), 8'd1);

        // Starve to death, then check MUERTO is sticky.
        assert_reset_now("rst_c");
        step();
        reset = 1'b1;
        while (t < 349) step();
        chk("t349_comida", 8'(bus.nivel_comida), 8'd1);
        step();
        chk("t350_comida", 8'(bus.nivel_comida), 8'd0);
        while (t < 700) step();
        chk("t700_salud", 8'(bus.nivel_salud), 8'd0);
        chk("t700_estado", 8'(bus.estado), 8'd3);
        step();
        chk("t701_muerto", 8'(bus.estado), 8'd4);
        bc = 1'b1;
        bm = 1'b1;
        repeat (3) step();
        bc = 1'b0;
        bm = 1'b0;
        repeat (10) step();
        chk("dead_comida", 8'(bus.nivel_comida), 8'd0);
        chk("dead_salud", 8'(bus.nivel_salud), 8'd0);
        chk("dead_modo", 8'(bus.modo), 8'd0);
        chk("dead_estado", 8'(bus.estado), 8'd4);
        assert_reset_now("rst_dead");

        // Asynchronous reset in the middle of CURANDO.
        step();
        reset = 1'b1;
        bm = 1'b1;
        step();
        step();
        bm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.modo == 2'd2) break;
            step();
        end
        chk("curando_active", 8'(bus.modo), 8'd2);
        step();
        #2;
        assert_reset_now("rst_mid_curando");
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/maq_est_y_modos_ctrl.md
Name: maq_est_y_modos_ctrl

Overview:
- Virtual-pet state machine with care modes.
- Keeps two 3-bit well-being levels, comida and salud; both decay over time.
- Two push buttons replenish the levels.
- Derives a registered pet state (estado) from the levels, plus a transient activity mode (modo).
- Sits between debounced user buttons and the display/animation logic.

Parameters:
- CICLOS_HAMBRE, 50: clk cycles per 1-step decrement of nivel_comida.
- CICLOS_SALUD, 100: clk cycles per 1-step decrement of nivel_salud.
- CICLOS_MODO, 8: clk cycles a care mode stays active after a press.
- INCREMENTO, 2: level gain per button press.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Boton_Comida  input  1  feed button, active-high level.
- Boton_Medicina  input  1  medicine button, active-high level.
- nivel_comida  output  3  food level, 0..7.
- nivel_salud  output  3  health level, 0..7.
- estado  output  3  0=FELIZ, 1=NEUTRO, 2=HAMBRIENTO, 3=ENFERMO, 4=MUERTO.
- modo  output  2  0=NORMAL, 1=COMIENDO, 2=CURANDO, 3 unused.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- reset=0 forces immediately, without a clock:
  - nivel_comida=7, nivel_salud=7, estado=FELIZ, modo=NORMAL.
  - Decay counters, mode timer, synchronizers and edge detectors all cleared.
- Button input path:
  - Each button passes a 2-FF synchronizer, then a rising-edge detector, giving a 1-cycle pulse per press.
  - Holding a button produces exactly one pulse.
  - A level change is visible after the 3rd rising clk edge following the input going high.
- Decay:
  - Free-running counter per level, counting from reset release.
  - When the counter reaches N-1 it wraps to 0 and the level decrements by 1.
  - First decrement occurs on cycle N after release.
  - Levels saturate at 0.
- Feed (Boton_Comida pulse): nivel_comida += INCREMENTO, saturating at 7.
- Medicine (Boton_Medicina pulse): nivel_salud += INCREMENTO, saturating at 7.
- Press and decay in the same cycle: net change = +INCREMENTO-1, then saturate.
- estado is registered, one cycle after the levels. Priority:
  1. MUERTO: both levels 0.
  2. ENFERMO: salud<=2.
  3. HAMBRIENTO: comida<=2.
  4. FELIZ: both >=5.
  5. NEUTRO: otherwise.
- MUERTO is sticky until reset:
  - decay stops;
  - button pulses are ignored;
  - modo is forced to NORMAL.
- modo:
  - A feed pulse loads COMIENDO with timer=CICLOS_MODO.
  - A medicine pulse loads CURANDO with timer=CICLOS_MODO.
  - Timer decrements each cycle; modo returns to NORMAL after CICLOS_MODO cycles.
  - A new press while a mode is active restarts the timer and takes the new mode.
  - Both pulses in the same cycle: both levels update; modo=COMIENDO.
  - A press at level 7 still enters the mode; the level stays 7.
- Reset asserted mid-mode or mid-decay aborts everything to the reset values.

Test Plan:
- Hold reset=0 for 10 cycles, toggling buttons -> nivel_comida=7, nivel_salud=7, estado=0, modo=0 throughout. Release -> no change for 49 cycles.
- No buttons for 250 cycles after release -> nivel_comida=2, nivel_salud=5, estado=HAMBRIENTO(2) one cycle later.
- From comida=2, one 20-cycle feed press -> comida=4 after 3 edges (single increment); modo=COMIENDO for 8 cycles then NORMAL; estado=NEUTRO.
- Feed at comida=7 -> stays 7, modo=COMIENDO. Both buttons same cycle -> comida+2 and salud+2 (saturated), modo=COMIENDO.
- No buttons for 700 cycles -> comida=0 at 350, salud=0 at 700, estado=MUERTO. Further presses -> levels 0, modo=0. reset=0 -> immediately 7/7/FELIZ.
- Assert reset asynchronously mid-CURANDO (between clk edges) -> modo=0 and levels=7 before the next clk edge.
